al_accel_bpbuf_wb: RTL and testbench

AL_ACCEL_BPBUF_WB -- requirements
Module: al_accel_bpbuf_wb

---
 rtl/al_accel_bpbuf_wb_if.sv | 27 ++
 rtl/al_accel_bpbuf_wb.sv | 121 ++++++++++++
 tb/tb_al_accel_bpbuf_wb.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/al_accel_bpbuf_wb_if.sv
// Memory write channel between the bypass-buffer drain engine and memory.
// The engine is the master; the memory (or its bus bridge) is the slave.
interface al_accel_bpbuf_wb_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/al_accel_bpbuf_wb.sv
// Drains word_cnt 32-bit words from the bypass buffer and writes them to
// consecutive word addresses starting at base_addr, one word per transaction.
module al_accel_bpbuf_wb #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enb,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     word_cnt,
  output logic                 bpbuf_rd_req,
  input  logic                 bpbuf_rd_vld,
  input  logic [31:0]          bpbuf_do,
  al_accel_bpbuf_wb_if.master  mem,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [CNT_W-1:0]   rem_q;
  logic [31:0]        data_q;

  logic               start_acc;
  logic               rd_fire;
  logic               wr_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs are decoded from state so that an asynchronous reset
  // clears mem_valid/busy/rd_req immediately, without waiting for a clock.
  always_comb begin
    state_d        = state_q;
    bpbuf_rd_req   = 1'b0;
    mem.mem_valid  = 1'b0;
    mem.mem_wstrb  = 4'h0;
    busy           = 1'b1;
    done           = 1'b0;
    start_acc      = 1'b0;
    rd_fire        = 1'b0;
    wr_fire        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_d   = (word_cnt != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        bpbuf_rd_req = enb;
        if (enb && bpbuf_rd_vld) begin
          rd_fire = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // enb is deliberately not looked at here: a posted write never drops.
        mem.mem_valid = 1'b1;
        mem.mem_wstrb = 4'hF;
        if (mem.mem_ready) begin
          wr_fire = 1'b1;
          state_d = (rem_q > CNT_W'(1)) ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // mem_addr has its own register, loaded at capture, so it holds the
  // address of the last write while addr_q has already advanced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      mem_addr_q <= '0;
      rem_q      <= '0;
      data_q     <= '0;
    end else begin
      if (start_acc) begin
        addr_q <= base_addr & ~ADDR_W'(3);
        rem_q  <= word_cnt;
      end
      if (rd_fire) begin
        data_q     <= bpbuf_do;
        mem_addr_q <= addr_q;
      end
      if (wr_fire) begin
        addr_q <= addr_q + ADDR_W'(4);
        rem_q  <= rem_q - CNT_W'(1);
      end
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = data_q;

endmodule

// File: tb/tb_al_accel_bpbuf_wb.sv
// Directed bench for al_accel_bpbuf_wb: cycle-by-cycle checks of the drain
// sequence, stalls, address wrap, reset abandonment and start-while-busy.
module tb_al_accel_bpbuf_wb;

  logic        clk;
  logic        resetn;
  logic        enb;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic        bpbuf_rd_req;
  logic        bpbuf_rd_vld;
  logic [31:0] bpbuf_do;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  al_accel_bpbuf_wb_if #(.ADDR_W(32)) mem_if ();

  al_accel_bpbuf_wb #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enb          (enb),
    .start        (start),
    .base_addr    (base_addr),
    .word_cnt     (word_cnt),
    .bpbuf_rd_req (bpbuf_rd_req),
    .bpbuf_rd_vld (bpbuf_rd_vld),
    .bpbuf_do     (bpbuf_do),
    .mem          (mem_if),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Returns on the falling edge after the accepting rising edge.
  task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    base_addr = a;
    word_cnt  = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bpbuf_rd_req, mem_if.mem_valid, busy, done, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata} !== 72'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {bpbuf_rd_req, mem_if.mem_valid, busy, done, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bpbuf_rd_req, mem_if.mem_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_held got %b exp 0000", {bpbuf_rd_req, mem_if.mem_valid, busy, done});
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    mem_if.mem_ready = 1'b1;
    bpbuf_rd_vld     = 1'b1;
    bpbuf_do         = 32'h5876063e;
    pulse_start(32'h100, 16'd2);
    checks++;
    if ({bpbuf_rd_req, busy, mem_if.mem_valid, done} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_fetch0 got %b exp 1100", {bpbuf_rd_req, busy, mem_if.mem_valid, done});
    end
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata, bpbuf_rd_req} !== {1'b1, 4'hF, 32'h100, 32'h5876063e, 1'b0}) begin
      errors++;
      $display("FAIL basic_write0 got %h exp %h", {mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata, bpbuf_rd_req}, {1'b1, 4'hF, 32'h100, 32'h5876063e, 1'b0});
    end
    bpbuf_do = 32'haabb7788;
    @(negedge clk);
    checks++;
    if ({bpbuf_rd_req, mem_if.mem_valid, mem_if.mem_wstrb} !== 6'b100000) begin
      errors++;
      $display("FAIL basic_fetch1 got %b exp 100000", {bpbuf_rd_req, mem_if.mem_valid, mem_if.mem_wstrb});
    end
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 4'hF, 32'h104, 32'haabb7788}) begin
      errors++;
      $display("FAIL basic_write1 got %h exp %h", {mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 4'hF, 32'h104, 32'haabb7788});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h104, 32'haabb7788}) begin
      errors++;
      $display("FAIL basic_done got %h exp %h", {done, busy, mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 1'b1, 1'b0, 4'h0, 32'h104, 32'haabb7788});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, bpbuf_rd_req, mem_if.mem_valid} !== 4'b0) begin
      errors++;
      $display("FAIL basic_idle got %b exp 0000", {done, busy, bpbuf_rd_req, mem_if.mem_valid});
    end
  endtask

  task automatic test_zero_count();
    pulse_start(32'h10, 16'd0);
    checks++;
    if ({done, busy, bpbuf_rd_req, mem_if.mem_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_done got %b exp 1100", {done, busy, bpbuf_rd_req, mem_if.mem_valid});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, bpbuf_rd_req, mem_if.mem_valid} !== 4'b0) begin
      errors++;
      $display("FAIL zero_idle got %b exp 0000", {done, busy, bpbuf_rd_req, mem_if.mem_valid});
    end
  endtask

  task automatic test_stall();
    mem_if.mem_ready = 1'b0;
    bpbuf_do         = 32'hcafef00d;
    pulse_start(32'h40, 16'd1);
    @(negedge clk);
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata, done} !== {1'b1, 4'hF, 32'h40, 32'hcafef00d, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h exp %h", i, {mem_if.mem_valid, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata, done}, {1'b1, 4'hF, 32'h40, 32'hcafef00d, 1'b0});
      end
      @(negedge clk);
    end
    mem_if.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, mem_if.mem_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_complete got %b exp 10", {done, mem_if.mem_valid});
    end
    // FETCH with enb low: rd_vld must be ignored while no request is out.
    bpbuf_do = 32'h0badf00d;
    pulse_start(32'h50, 16'd1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bpbuf_rd_req, busy, mem_if.mem_valid} !== 3'b010) begin
        errors++;
        $display("FAIL fetch_stall%0d got %b exp 010", i, {bpbuf_rd_req, busy, mem_if.mem_valid});
      end
      @(negedge clk);
    end
    enb = 1'b1;
    #1;
    checks++;
    if (bpbuf_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_resume got %b exp 1", bpbuf_rd_req);
    end
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 32'h50, 32'h0badf00d}) begin
      errors++;
      $display("FAIL fetch_stall_write got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 32'h50, 32'h0badf00d});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bpbuf_do = 32'h01020304;
    pulse_start(32'hFFFFFFFC, 16'd2);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr} !== {1'b1, 32'hFFFFFFFC}) begin
      errors++;
      $display("FAIL wrap_addr0 got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr}, {1'b1, 32'hFFFFFFFC});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr} !== {1'b1, 32'h00000000}) begin
      errors++;
      $display("FAIL wrap_addr1 got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr}, {1'b1, 32'h00000000});
    end
    @(negedge clk);
    @(negedge clk);
    // Low two address bits are dropped.
    pulse_start(32'h00000307, 16'd1);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr} !== {1'b1, 32'h304}) begin
      errors++;
      $display("FAIL align_addr got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr}, {1'b1, 32'h304});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_if.mem_ready = 1'b0;
    bpbuf_do         = 32'h11111111;
    pulse_start(32'h80, 16'd3);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL rstmid_inwrite got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr}, {1'b1, 32'h80});
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_if.mem_valid, busy, done, bpbuf_rd_req, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata} !== 72'h0) begin
      errors++;
      $display("FAIL rstmid_async got %h exp 0", {mem_if.mem_valid, busy, done, bpbuf_rd_req, mem_if.mem_wstrb, mem_if.mem_addr, mem_if.mem_wdata});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done, busy, mem_if.mem_valid} !== 3'b0) begin
      errors++;
      $display("FAIL rstmid_nodone got %b exp 000", {done, busy, mem_if.mem_valid});
    end
    resetn           = 1'b1;
    mem_if.mem_ready = 1'b1;
    bpbuf_do         = 32'h22222222;
    pulse_start(32'h200, 16'd1);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 32'h200, 32'h22222222}) begin
      errors++;
      $display("FAIL rstmid_fresh got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 32'h200, 32'h22222222});
    end
    @(negedge clk);
    checks++;
    if ({done, mem_if.mem_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_done got %b exp 10", {done, mem_if.mem_valid});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, mem_if.mem_valid, done} !== 3'b0) begin
      errors++;
      $display("FAIL rstmid_single got %b exp 000", {busy, mem_if.mem_valid, done});
    end
  endtask

  task automatic test_start_busy();
    bpbuf_do = 32'h33333333;
    pulse_start(32'h300, 16'd2);
    start     = 1'b1;
    base_addr = 32'h900;
    word_cnt  = 16'd5;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL busy_addr0 got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr}, {1'b1, 32'h300});
    end
    bpbuf_do = 32'h44444444;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 32'h304, 32'h44444444}) begin
      errors++;
      $display("FAIL busy_addr1 got %h exp %h", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 32'h304, 32'h44444444});
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, mem_if.mem_valid} !== 2'b10) begin
      errors++;
      $display("FAIL busy_done got %b exp 10", {done, mem_if.mem_valid});
    end
    @(negedge clk);
    checks++;
    if ({busy, done, bpbuf_rd_req} !== 3'b0) begin
      errors++;
      $display("FAIL busy_idle got %b exp 000", {busy, done, bpbuf_rd_req});
    end
  endtask

  initial begin
    resetn           = 1'b0;
    enb              = 1'b1;
    start            = 1'b0;
    base_addr        = '0;
    word_cnt         = '0;
    bpbuf_rd_vld     = 1'b1;
    bpbuf_do         = '0;
    mem_if.mem_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_count();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
